// File: rtl/bram_pkg.sv
// Shared constants and helpers for the dual-port local-memory BRAM controller.
package bram_pkg;

    localparam int WM_READ_FIRST  = 0;
    localparam int WM_WRITE_FIRST = 1;
    localparam int COLL_CNT_W     = 16;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/bram_dp_block_ctrl_if.sv
// One BRAM access port: master issues accesses, the RAM returns read data.
interface bram_dp_block_ctrl_if #(
    parameter int C_AWIDTH = 32,
    parameter int C_DWIDTH = 32
);
    localparam int C_NUM_WE = C_DWIDTH / 8;

    // EN qualifies WEN/Addr/Dout on each clock edge; there is no back-pressure,
    // so every enabled access yields exactly one RdVld pulse a fixed latency later.
    // Lanes are MSB-first: WEN's top bit enables the data's top byte.
    logic                EN;
    logic [C_NUM_WE-1:0] WEN;
    logic [C_AWIDTH-1:0] Addr;
    logic [C_DWIDTH-1:0] Dout;
    logic [C_DWIDTH-1:0] Din;
    logic                RdVld;
    logic                AddrErr;

    modport master (output EN, WEN, Addr, Dout, input Din, RdVld, AddrErr);
    modport slave  (input EN, WEN, Addr, Dout, output Din, RdVld, AddrErr);

endinterface

// File: rtl/bram_dp_array.sv
// Inferred single-clock true dual-port storage with byte enables and per-port
// read-first / write-first return data. Write masks arrive already arbitrated.
module bram_dp_array
    import bram_pkg::*;
#(
    parameter int DEPTH   = 4096,
    parameter int IW      = 12,
    parameter int DWIDTH  = 32,
    parameter int NUM_WE  = 4,
    parameter int WR_MODE = WM_READ_FIRST
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_a,
    input  logic              wr_a,
    input  logic [NUM_WE-1:0] we_a,
    input  logic [IW-1:0]     idx_a,
    input  logic [DWIDTH-1:0] wdata_a,
    output logic [DWIDTH-1:0] rdata_a,
    input  logic              en_b,
    input  logic              wr_b,
    input  logic [NUM_WE-1:0] we_b,
    input  logic [IW-1:0]     idx_b,
    input  logic [DWIDTH-1:0] wdata_b,
    output logic [DWIDTH-1:0] rdata_b
);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [DWIDTH-1:0] word_a, word_b, fwd_a, fwd_b;

    function automatic logic [DWIDTH-1:0] merge_lanes(input logic [DWIDTH-1:0] old_word,
                                                      input logic [NUM_WE-1:0] we,
                                                      input logic [DWIDTH-1:0] wd);
        logic [DWIDTH-1:0] result;
        result = old_word;
        for (int l = 0; l < NUM_WE; l++) begin
            if (we[l]) result[l*8 +: 8] = wd[l*8 +: 8];
        end
        return result;
    endfunction

    assign word_a = mem[idx_a];
    assign word_b = mem[idx_b];

    // Write-first data is the word as it will be stored, including lanes the other port wins.
    always_comb begin
        fwd_a = merge_lanes(word_a, we_a, wdata_a);
        fwd_b = merge_lanes(word_b, we_b, wdata_b);
        if (idx_a == idx_b) begin
            fwd_a = merge_lanes(fwd_a, we_b, wdata_b);
            fwd_b = merge_lanes(fwd_b, we_a, wdata_a);
        end
    end

    always_ff @(posedge clk) begin
        for (int l = 0; l < NUM_WE; l++) begin
            if (we_a[l]) mem[idx_a][l*8 +: 8] <= wdata_a[l*8 +: 8];
            if (we_b[l]) mem[idx_b][l*8 +: 8] <= wdata_b[l*8 +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_a <= '0;
            rdata_b <= '0;
        end else begin
            if (en_a) rdata_a <= (WR_MODE == WM_WRITE_FIRST && wr_a) ? fwd_a : word_a;
            if (en_b) rdata_b <= (WR_MODE == WM_WRITE_FIRST && wr_b) ? fwd_b : word_b;
        end
    end

endmodule

// File: rtl/bram_dp_block_ctrl.sv
// Parametrised dual-port local-memory BRAM: range check, same-word collision
// arbitration and counting, and an optional second read-data register.
module bram_dp_block_ctrl
    import bram_pkg::*;
#(
    parameter int C_MEMSIZE    = 'h4000,
    parameter int C_DWIDTH     = 32,
    parameter int C_AWIDTH     = 32,
    parameter int C_NUM_WE     = C_DWIDTH / 8,
    parameter int C_RD_LATENCY = 1,
    parameter int C_WR_MODE    = WM_READ_FIRST,
    parameter int C_PRIO_B     = 0
) (
    input  logic                  BRAM_Clk,
    input  logic                  BRAM_Rst_N,
    bram_dp_block_ctrl_if.slave   bram_a,
    bram_dp_block_ctrl_if.slave   bram_b,
    output logic                  BRAM_Collision,
    output logic [COLL_CNT_W-1:0] BRAM_CollCnt
);

    localparam int LANE_BITS = clog2(C_NUM_WE);
    localparam int DEPTH     = C_MEMSIZE / C_NUM_WE;
    localparam int IW        = clog2(DEPTH);
    localparam logic [C_AWIDTH:0] ADDR_LIMIT = (C_AWIDTH + 1)'(C_MEMSIZE);

    if (C_RD_LATENCY != 1 && C_RD_LATENCY != 2) begin : g_bad_latency
        $error("bram_dp_block_ctrl: C_RD_LATENCY must be 1 or 2");
    end

    logic                  oor_a, oor_b, acc_a, acc_b, wr_a, wr_b, same_word, coll;
    logic [IW-1:0]         idx_a, idx_b;
    logic [C_NUM_WE-1:0]   both_we, we_a, we_b;
    logic [C_DWIDTH-1:0]   raw_a, raw_b, din1_a, din1_b, din2_a, din2_b;
    logic                  vld1_a, vld1_b, err1_a, err1_b;
    logic                  vld2_a, vld2_b, err2_a, err2_b;
    logic [COLL_CNT_W-1:0] coll_cnt_q;

    assign idx_a = bram_a.Addr[LANE_BITS +: IW];
    assign idx_b = bram_b.Addr[LANE_BITS +: IW];
    assign oor_a = {1'b0, bram_a.Addr} >= ADDR_LIMIT;
    assign oor_b = {1'b0, bram_b.Addr} >= ADDR_LIMIT;
    assign acc_a = bram_a.EN & ~oor_a;
    assign acc_b = bram_b.EN & ~oor_b;
    assign wr_a  = acc_a & (|bram_a.WEN);
    assign wr_b  = acc_b & (|bram_b.WEN);

    assign same_word = acc_a & acc_b & (idx_a == idx_b);
    assign coll      = same_word & (wr_a | wr_b);
    assign both_we   = same_word ? (bram_a.WEN & bram_b.WEN) : '0;

    // Lanes both ports write go to the priority port only; out-of-range writes are dropped.
    always_comb begin
        we_a = acc_a ? bram_a.WEN : '0;
        we_b = acc_b ? bram_b.WEN : '0;
        if (C_PRIO_B != 0) we_a = we_a & ~both_we;
        else               we_b = we_b & ~both_we;
    end

    bram_dp_array #(
        .DEPTH   (DEPTH),
        .IW      (IW),
        .DWIDTH  (C_DWIDTH),
        .NUM_WE  (C_NUM_WE),
        .WR_MODE (C_WR_MODE)
    ) u_array (
        .clk     (BRAM_Clk),
        .rst_n   (BRAM_Rst_N),
        .en_a    (bram_a.EN),
        .wr_a    (wr_a),
        .we_a    (we_a),
        .idx_a   (idx_a),
        .wdata_a (bram_a.Dout),
        .rdata_a (raw_a),
        .en_b    (bram_b.EN),
        .wr_b    (wr_b),
        .we_b    (we_b),
        .idx_b   (idx_b),
        .wdata_b (bram_b.Dout),
        .rdata_b (raw_b)
    );

    // err1 only moves with an access so Din keeps its last value while idle.
    assign din1_a = err1_a ? '0 : raw_a;
    assign din1_b = err1_b ? '0 : raw_b;

    always_ff @(posedge BRAM_Clk or negedge BRAM_Rst_N) begin
        if (!BRAM_Rst_N) begin
            vld1_a         <= 1'b0;
            vld1_b         <= 1'b0;
            err1_a         <= 1'b0;
            err1_b         <= 1'b0;
            vld2_a         <= 1'b0;
            vld2_b         <= 1'b0;
            err2_a         <= 1'b0;
            err2_b         <= 1'b0;
            din2_a         <= '0;
            din2_b         <= '0;
            BRAM_Collision <= 1'b0;
            coll_cnt_q     <= '0;
        end else begin
            vld1_a <= bram_a.EN;
            vld1_b <= bram_b.EN;
            if (bram_a.EN) err1_a <= oor_a;
            if (bram_b.EN) err1_b <= oor_b;
            vld2_a <= vld1_a;
            vld2_b <= vld1_b;
            if (vld1_a) begin
                din2_a <= din1_a;
                err2_a <= err1_a;
            end
            if (vld1_b) begin
                din2_b <= din1_b;
                err2_b <= err1_b;
            end
            BRAM_Collision <= coll;
            if (coll && coll_cnt_q != '1) coll_cnt_q <= coll_cnt_q + COLL_CNT_W'(1);
        end
    end

    assign bram_a.Din     = (C_RD_LATENCY == 2) ? din2_a : din1_a;
    assign bram_b.Din     = (C_RD_LATENCY == 2) ? din2_b : din1_b;
    assign bram_a.RdVld   = (C_RD_LATENCY == 2) ? vld2_a : vld1_a;
    assign bram_b.RdVld   = (C_RD_LATENCY == 2) ? vld2_b : vld1_b;
    assign bram_a.AddrErr = (C_RD_LATENCY == 2) ? (vld2_a & err2_a) : (vld1_a & err1_a);
    assign bram_b.AddrErr = (C_RD_LATENCY == 2) ? (vld2_b & err2_b) : (vld1_b & err1_b);
    assign BRAM_CollCnt   = coll_cnt_q;

endmodule
